iomem_gpio: RTL and testbench

- Parametrised GPIO peripheral on the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata), decoded in the iomem region (addr[31:24] > 8'h01).
- Generalises the single hard-wired active-low LED register to GPIO_WIDTH pins.
- Adds per-pin output enable, synchronised inputs, rising-edge capture with sticky pending bits, and a level interrupt output.
- Sits between the CPU bus mux and the board pins; the SoC top ORs its mem_ready into the CPU ready.

---
 rtl/iomem_gpio.sv | 170 +++++++++++++++++
 tb/tb_iomem_gpio.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio.sv
// iomem_gpio: GPIO peripheral on the PicoRV32 native memory bus.
//
// Registers (offset = addr[7:2] word index, shown as byte offset):
//   0x00 OUT   R/W  pin output values
//   0x04 IN    RO   synchronised pin inputs
//   0x08 OE    R/W  per-pin output enable, 1 = drive
//   0x0C PEND  W1C  sticky rising-edge flags
//   0x10 IEN   R/W  per-pin interrupt enable
//   0x14 OUT_SET / 0x18 OUT_CLR  write-only bit set/clear of OUT, read back OUT
//        (present only when IOMEM_GPIO_SETCLR_EN is defined; otherwise unmapped)
//
// Every hit is acknowledged with a single-cycle mem_ready pulse one cycle after
// the request; mem_rdata is zero whenever mem_ready is low so the SoC can OR
// read data from several peripherals.

module iomem_gpio #(
  parameter int                    GPIO_WIDTH = 8,
  parameter logic [31:0]           BASE_ADDR  = 32'h0200_0000,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET  = '1,
  parameter logic [GPIO_WIDTH-1:0] OE_RESET   = '1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [5:0] OFF_OUT  = 6'h00;
  localparam logic [5:0] OFF_IN   = 6'h01;
  localparam logic [5:0] OFF_OE   = 6'h02;
  localparam logic [5:0] OFF_PEND = 6'h03;
  localparam logic [5:0] OFF_IEN  = 6'h04;
`ifdef IOMEM_GPIO_SETCLR_EN
  localparam logic [5:0] OFF_SET  = 6'h05;
  localparam logic [5:0] OFF_CLR  = 6'h06;
`endif

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] oe_q, oe_d;
  logic [GPIO_WIDTH-1:0] pend_q, pend_d;
  logic [GPIO_WIDTH-1:0] ien_q, ien_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic                  hit;
  logic                  sel;
  logic                  wr;
  logic [5:0]            off;
  logic [31:0]           strb_mask32;
  logic [GPIO_WIDTH-1:0] lane_mask;
  logic [GPIO_WIDTH-1:0] wdat;
  logic [GPIO_WIDTH-1:0] w1c;
  logic [GPIO_WIDTH-1:0] rise;
  logic [31:0]           rd_val;

  // Address decode and handshake qualification; !ready_q keeps a held request
  // from being taken twice.
  assign hit = (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign sel = mem_valid && hit && !ready_q;
  assign wr  = sel && (mem_wstrb != 4'b0000);
  assign off = mem_addr[7:2];

  // Byte strobes expanded to bit mask; lanes above GPIO_WIDTH fall off here.
  assign strb_mask32 = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                        {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign lane_mask   = strb_mask32[GPIO_WIDTH-1:0];
  assign wdat        = mem_wdata[GPIO_WIDTH-1:0] & lane_mask;

  assign rise = sync2_q & ~prev_q;

  // Register writes, sticky pending update (set beats clear) and irq level.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    ien_d = ien_q;
    w1c   = '0;
    if (wr) begin
      case (off)
        OFF_OUT:  out_d = (out_q & ~lane_mask) | wdat;
        OFF_OE:   oe_d  = (oe_q  & ~lane_mask) | wdat;
        OFF_PEND: w1c   = wdat;
        OFF_IEN:  ien_d = (ien_q & ~lane_mask) | wdat;
`ifdef IOMEM_GPIO_SETCLR_EN
        OFF_SET:  out_d = out_q | wdat;
        OFF_CLR:  out_d = out_q & ~wdat;
`endif
        default:  ;
      endcase
    end
    pend_d = (pend_q & ~w1c) | rise;
    irq_d  = |(pend_q & ien_q);
  end

  // Read mux; PEND returns the pre-update value so a same-cycle edge is not lost
  // from software's view (it shows on the next read).
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_OUT:  rd_val[GPIO_WIDTH-1:0] = out_q;
      OFF_IN:   rd_val[GPIO_WIDTH-1:0] = sync2_q;
      OFF_OE:   rd_val[GPIO_WIDTH-1:0] = oe_q;
      OFF_PEND: rd_val[GPIO_WIDTH-1:0] = pend_q;
      OFF_IEN:  rd_val[GPIO_WIDTH-1:0] = ien_q;
`ifdef IOMEM_GPIO_SETCLR_EN
      OFF_SET,
      OFF_CLR:  rd_val[GPIO_WIDTH-1:0] = out_q;
`endif
      default:  rd_val = '0;
    endcase
    ready_d = sel;
    rdata_d = sel ? rd_val : 32'h0;
  end

  // Input synchroniser and edge-history chain.
  always_comb begin
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q   <= OUT_RESET;
      oe_q    <= OE_RESET;
      pend_q  <= '0;
      ien_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = oe_q;
  assign irq       = irq_q;

  // Byte-offset bits and lanes above GPIO_WIDTH are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata, strb_mask32};

endmodule

// File: tb/tb_iomem_gpio.sv
// Testbench for iomem_gpio (GPIO_WIDTH=8). Checks directed vectors, input-edge
// corner cases and randomized traffic against a cycle-level reference model.
// Expectations for 0x14/0x18 follow IOMEM_GPIO_SETCLR_EN.

module tb_iomem_gpio;
  localparam int W = 8;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic         clk = 1'b0;
  logic         resetn;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  iomem_gpio #(.GPIO_WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_out, m_oe, m_pend, m_ien;
  logic         m_irq;
  logic [W-1:0] h [0:3];   // h[0] = pin value sampled at the latest edge
  logic         pw_valid;
  logic [5:0]   pw_off;
  logic [31:0]  pw_data;
  logic [3:0]   pw_strb;
  logic         live_chk;
`ifdef IOMEM_GPIO_SETCLR_EN
  localparam bit SETCLR = 1'b1;
`else
  localparam bit SETCLR = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '1; m_oe = '1; m_pend = '0; m_ien = '0; m_irq = 1'b0;
    for (int i = 0; i < 4; i++) h[i] = '0;
    pw_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] off);
    logic [31:0] r;
    r = 32'h0;
    case (off)
      6'h00: r[W-1:0] = m_out;
      6'h01: r[W-1:0] = h[1];
      6'h02: r[W-1:0] = m_oe;
      6'h03: r[W-1:0] = m_pend;
      6'h04: r[W-1:0] = m_ien;
      6'h05, 6'h06: if (SETCLR) r[W-1:0] = m_out;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // One clock edge: advance the model, then optionally compare pin outputs.
  task automatic tick();
    logic [W-1:0] rise, mask, d, w1c;
    logic [31:0]  m32;
    @(posedge clk);
    m_irq = |(m_pend & m_ien);
    rise  = h[1] & ~h[2];
    w1c   = '0;
    if (pw_valid) begin
      m32  = {{8{pw_strb[3]}}, {8{pw_strb[2]}}, {8{pw_strb[1]}}, {8{pw_strb[0]}}};
      mask = m32[W-1:0];
      d    = pw_data[W-1:0] & mask;
      case (pw_off)
        6'h00: m_out = (m_out & ~mask) | d;
        6'h02: m_oe  = (m_oe  & ~mask) | d;
        6'h03: w1c   = d;
        6'h04: m_ien = (m_ien & ~mask) | d;
        6'h05: if (SETCLR) m_out = m_out | d;
        6'h06: if (SETCLR) m_out = m_out & ~d;
        default: ;
      endcase
    end
    m_pend = (m_pend & ~w1c) | rise;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = gpio_in;
    #1;
    if (live_chk) begin
      chk("gpio_out_model", {24'h0, gpio_out}, {24'h0, m_out});
      chk("gpio_oe_model",  {24'h0, gpio_oe},  {24'h0, m_oe});
      chk("irq_model",      {31'h0, irq},      {31'h0, m_irq});
    end
  endtask

  // Full bus transfer to a hit address; checks 1-cycle ack and the idle cycle after.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    int waited;
    logic [31:0] exp_rd;
    exp_rd    = model_read(addr[7:2]);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    pw_valid  = 1'b1; pw_off = addr[7:2]; pw_data = wd; pw_strb = ws;
    tick();
    pw_valid  = 1'b0;
    waited    = 1;
    while (!mem_ready && waited < 4) begin
      tick();
      waited++;
    end
    chk("ack_latency", mem_ready ? waited : 99, 32'd1);
    rd = mem_rdata;
    if (ws == 4'b0000) chk("rdata_model", rd, exp_rd);
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
    tick();
    chk("ready_pulse_end", {31'h0, mem_ready}, 32'h0);
    chk("rdata_idle_zero", mem_rdata, 32'h0);
  endtask

  task automatic nohit(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input int cycles);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("nohit_ready", {31'h0, mem_ready}, 32'h0);
      chk("nohit_rdata", mem_rdata, 32'h0);
    end
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] rd, rnd;
    logic [7:0]  off;
    logic [3:0]  ws;

    tbl[0]  = '{8'h00, 32'h0000_005A, 4'b0001, 32'h0,  8'h5A, 8'hFF};
    tbl[1]  = '{8'h00, 32'h0,         4'b0000, 32'h5A, 8'h5A, 8'hFF};
    tbl[2]  = '{8'h00, 32'hFFFF_FF00, 4'b0010, 32'h0,  8'h5A, 8'hFF};
    tbl[3]  = '{8'h00, 32'h0,         4'b0000, 32'h5A, 8'h5A, 8'hFF};
    tbl[4]  = '{8'h08, 32'h0,         4'b0000, 32'hFF, 8'h5A, 8'hFF};
    tbl[5]  = '{8'h08, 32'h0000_00C3, 4'b0001, 32'h0,  8'h5A, 8'hC3};
    tbl[6]  = '{8'h08, 32'h0,         4'b0000, 32'hC3, 8'h5A, 8'hC3};
    tbl[7]  = '{8'h00, 32'hA5A5_A5A5, 4'b1110, 32'h0,  8'h5A, 8'hC3};
    tbl[8]  = '{8'h00, 32'h0,         4'b0000, 32'h5A, 8'h5A, 8'hC3};
    tbl[9]  = '{8'h0C, 32'h0,         4'b0000, 32'h0,  8'h5A, 8'hC3};
    tbl[10] = '{8'h04, 32'h0,         4'b0000, 32'h0,  8'h5A, 8'hC3};
    tbl[11] = '{8'h08, 32'hFFFF_FFFF, 4'b0001, 32'h0,  8'h5A, 8'hFF};
    tbl[12] = '{8'h10, 32'h0,         4'b0000, 32'h0,  8'h5A, 8'hFF};

    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_wstrb = 4'b0000; gpio_in = '0; live_chk = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'hFF);
    chk("rst_gpio_oe",  {24'h0, gpio_oe},  32'hFF);
    chk("rst_irq",      {31'h0, irq},      32'h0);
    chk("rst_ready",    {31'h0, mem_ready}, 32'h0);
    chk("rst_rdata",    mem_rdata, 32'h0);
    live_chk = 1'b1;

    bus(BASE + 32'h00, 32'h0, 4'b0000, rd);
    chk("rst_read_out", rd, 32'h0000_00FF);

    for (int i = 0; i < 13; i++) begin
      bus(BASE + {24'h0, tbl[i].off}, tbl[i].wdata, tbl[i].wstrb, rd);
      if (tbl[i].wstrb == 4'b0000) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_out", i), {24'h0, gpio_out}, {24'h0, tbl[i].exp_out});
      chk($sformatf("tbl%0d_oe", i),  {24'h0, gpio_oe},  {24'h0, tbl[i].exp_oe});
    end

    // Rising edge on bit3: IN after 2 edges, PEND after 3, then irq set/clear
    gpio_in = 8'h08;
    tick();
    bus(BASE + 32'h04, 32'h0, 4'b0000, rd);
    chk("in_too_early", rd, 32'h00);
    bus(BASE + 32'h04, 32'h0, 4'b0000, rd);
    chk("in_bit3", rd, 32'h08);
    bus(BASE + 32'h0C, 32'h0, 4'b0000, rd);
    chk("pend_bit3", rd, 32'h08);
    bus(BASE + 32'h10, 32'h08, 4'b0001, rd);
    chk("irq_set", {31'h0, irq}, 32'h1);
    bus(BASE + 32'h0C, 32'h08, 4'b0001, rd);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    bus(BASE + 32'h0C, 32'h0, 4'b0000, rd);
    chk("pend_cleared", rd, 32'h00);

    // PEND read on the same edge as the set returns the old value
    gpio_in = 8'h28;
    tick(); tick();
    bus(BASE + 32'h0C, 32'h0, 4'b0000, rd);
    chk("pend_read_pre_set", rd, 32'h00);
    bus(BASE + 32'h0C, 32'h0, 4'b0000, rd);
    chk("pend_bit5", rd, 32'h20);
    bus(BASE + 32'h0C, 32'h20, 4'b0001, rd);

    // Rise and W1C on bit3 in the same cycle: set wins
    gpio_in = 8'h20;
    tick(); tick(); tick();
    gpio_in = 8'h28;
    tick(); tick();
    bus(BASE + 32'h0C, 32'h08, 4'b0001, rd);
    bus(BASE + 32'h0C, 32'h0, 4'b0000, rd);
    chk("pend_set_wins", rd, 32'h08);
    bus(BASE + 32'h0C, 32'hFF, 4'b0001, rd);

    // Non-hit address and unmapped offset
    nohit(32'h0100_0000, 32'h0, 4'b0001, 4);
    bus(BASE + 32'h00, 32'h0, 4'b0000, rd);
    chk("nohit_out_kept", rd, 32'h5A);
    bus(BASE + 32'h3C, 32'hFFFF_FFFF, 4'b1111, rd);
    bus(BASE + 32'h3C, 32'h0, 4'b0000, rd);
    chk("unmapped_read", rd, 32'h0);
    chk("unmapped_out_kept", {24'h0, gpio_out}, 32'h5A);
    chk("unmapped_oe_kept",  {24'h0, gpio_oe},  32'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom;
      if (rnd[1:0] == 2'b00) begin
        rnd = $urandom;
        gpio_in = rnd[W-1:0];
      end
      rnd = $urandom;
      case (rnd[3:0])
        4'd0, 4'd1, 4'd2: off = {2'b0, rnd[6:4], 2'b00};
        4'd3: off = 8'h14;
        4'd4: off = 8'h18;
        4'd5: off = 8'h3C;
        4'd6: off = 8'h0C;
        default: off = {3'b0, rnd[7:5] % 3'd5, 2'b00};
      endcase
      ws = rnd[8] ? 4'b0000 : rnd[12:9];
      if (rnd[15:13] == 3'b000) begin
        nohit(32'h0300_0000 | {24'h0, off}, $urandom, ws, 2);
      end else if (rnd[15:13] == 3'b001) begin
        tick();
      end else begin
        bus(BASE + {24'h0, off}, $urandom, ws, rd);
      end
    end

    // Reset during an acknowledged transfer: ready drops immediately
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'b0000;
    tick();
    chk("pre_abort_ready", {31'h0, mem_ready}, 32'h1);
    live_chk = 1'b0;
    resetn = 1'b0;
    #1;
    chk("abort_ready", {31'h0, mem_ready}, 32'h0);
    chk("abort_out_reset", {24'h0, gpio_out}, 32'hFF);
    mem_valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    gpio_in = '0;
    model_reset();
    live_chk = 1'b1;

    // OUT_SET / OUT_CLR
    bus(BASE + 32'h00, 32'h0F, 4'b0001, rd);
    bus(BASE + 32'h14, 32'h30, 4'b0001, rd);
    chk("setclr_set", {24'h0, gpio_out}, SETCLR ? 32'h3F : 32'h0F);
    bus(BASE + 32'h18, 32'h05, 4'b0001, rd);
    chk("setclr_clr", {24'h0, gpio_out}, SETCLR ? 32'h3A : 32'h0F);
    bus(BASE + 32'h14, 32'h0, 4'b0000, rd);
    chk("setclr_readback", rd, SETCLR ? 32'h3A : 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
